// File: rtl/pb_keyscan.sv
// Pushbutton front end: two-flop synchronizer, debounce FSM, highest-index priority encode.
// Optional auto-repeat while a key is held is enabled by defining PB_AUTOREPEAT_EN.
module pb_keyscan #(
    parameter int DEBOUNCE     = 3,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [20:0] pb,
    output logic [4:0]  keycode,
    output logic        strobe,
    output logic        held,
    output logic [7:0]  keycnt
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

    if (DEBOUNCE < 2 || DEBOUNCE > 255 || REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
        REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_param_check
        $error("pb_keyscan: parameter out of range");
    end

    logic [20:0] pb_m_reg;
    logic [20:0] pb_s_reg;
    state_t      state_reg,   state_next;
    logic [4:0]  cand_reg,    cand_next;
    logic [7:0]  cnt_reg,     cnt_next;
    logic [4:0]  keycode_reg, keycode_next;
    logic        strobe_reg,  strobe_next;
    logic        held_reg,    held_next;
    logic [7:0]  keycnt_reg,  keycnt_next;
    logic        any;
    logic [4:0]  code;

`ifdef PB_AUTOREPEAT_EN
    localparam logic [7:0] RPT_DELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0] RPT_RATE  = 8'(REPEAT_RATE);
    // Down-counter: loaded with the interval, a strobe fires on the cycle it would reach zero.
    logic [7:0]  rpt_reg, rpt_next;
`endif

    // Ascending scan so the highest pressed index wins.
    always_comb begin
        code = 5'd0;
        for (int i = 0; i < 21; i++) begin
            if (pb_s_reg[i]) begin
                code = 5'(i);
            end
        end
    end

    assign any = |pb_s_reg;

    always_comb begin
        state_next   = state_reg;
        cand_next    = cand_reg;
        cnt_next     = cnt_reg;
        keycode_next = keycode_reg;
        strobe_next  = 1'b0;
        keycnt_next  = keycnt_reg;
`ifdef PB_AUTOREPEAT_EN
        rpt_next     = rpt_reg;
`endif
        case (state_reg)
            IDLE: begin
`ifdef PB_AUTOREPEAT_EN
                rpt_next = 8'd0;
`endif
                if (any) begin
                    cand_next  = code;
                    cnt_next   = 8'd1;
                    state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!any || code != cand_reg) begin
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end else if (cnt_reg == DB_LAST) begin
                    keycode_next = cand_reg;
                    strobe_next  = 1'b1;
                    keycnt_next  = keycnt_reg + 8'd1;
                    state_next   = HELD;
`ifdef PB_AUTOREPEAT_EN
                    rpt_next     = RPT_DELAY;
`endif
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            HELD: begin
                // A different code while still pressed is deliberately not re-encoded.
                if (!any) begin
                    cnt_next   = 8'd1;
                    state_next = RELEASE_WAIT;
`ifdef PB_AUTOREPEAT_EN
                    rpt_next   = 8'd0;
`endif
                end
`ifdef PB_AUTOREPEAT_EN
                else if (rpt_reg <= 8'd1) begin
                    strobe_next = 1'b1;
                    keycnt_next = keycnt_reg + 8'd1;
                    rpt_next    = RPT_RATE;
                end else begin
                    rpt_next = rpt_reg - 8'd1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (any) begin
                    cnt_next   = 8'd0;
                    state_next = HELD;
`ifdef PB_AUTOREPEAT_EN
                    rpt_next   = RPT_DELAY;
`endif
                end else if (cnt_reg == DB_LAST) begin
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                cnt_next   = 8'd0;
                state_next = IDLE;
            end
        endcase
        held_next = (state_next == HELD) || (state_next == RELEASE_WAIT);
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            pb_m_reg    <= '0;
            pb_s_reg    <= '0;
            state_reg   <= IDLE;
            cand_reg    <= '0;
            cnt_reg     <= '0;
            keycode_reg <= '0;
            strobe_reg  <= 1'b0;
            held_reg    <= 1'b0;
            keycnt_reg  <= '0;
`ifdef PB_AUTOREPEAT_EN
            rpt_reg     <= '0;
`endif
        end else begin
            pb_m_reg    <= pb;
            pb_s_reg    <= pb_m_reg;
            state_reg   <= state_next;
            cand_reg    <= cand_next;
            cnt_reg     <= cnt_next;
            keycode_reg <= keycode_next;
            strobe_reg  <= strobe_next;
            held_reg    <= held_next;
            keycnt_reg  <= keycnt_next;
`ifdef PB_AUTOREPEAT_EN
            rpt_reg     <= rpt_next;
`endif
        end
    end

    assign keycode = keycode_reg;
    assign strobe  = strobe_reg;
    assign held    = held_reg;
    assign keycnt  = keycnt_reg;

endmodule

// File: tb/tb_pb_keyscan.sv
// Self-checking bench for pb_keyscan: directed scenarios plus randomized presses
// compared against a latency/interval model of press acceptance and auto-repeat.
module tb_pb_keyscan;

    localparam int D  = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic        hz100 = 1'b0;
    logic        reset = 1'b1;
    logic [20:0] pb    = '0;
    logic [4:0]  keycode;
    logic        strobe;
    logic        held;
    logic [7:0]  keycnt;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_keycnt = 8'd0;
    logic [4:0]  last_code  = 5'd0;

    pb_keyscan #(
        .DEBOUNCE    (D),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR)
    ) dut (
        .hz100  (hz100),
        .reset  (reset),
        .pb     (pb),
        .keycode(keycode),
        .strobe (strobe),
        .held   (held),
        .keycnt (keycnt)
    );

    always #5 hz100 = ~hz100;

    task automatic tick();
        @(posedge hz100);
        #1;
    endtask

    // pb held high for edges 0..len-1 (clean). A press is accepted after D high samples,
    // giving a strobe after edge D+1; with auto-repeat, further strobes at RD, RD+RR, ...
    // cycles after that while the synchronized input is still high (through edge len+1).
    function automatic bit exp_str(int i, int len);
        int k;
        if (len < D) return 1'b0;
        if (i == D + 1) return 1'b1;
        k = i - (D + 1);
`ifdef PB_AUTOREPEAT_EN
        if (k >= RD && i <= len + 1 && ((k - RD) % RR) == 0) return 1'b1;
`endif
        if (k < 0) return 1'b0;
        return 1'b0;
    endfunction

    function automatic logic [4:0] top_index(logic [20:0] m);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < 21; i++) if (m[i]) r = 5'(i);
        return r;
    endfunction

    task automatic drive_press(input logic [20:0] mask, input int len, input int gap,
                               output int bad, output int nstr, output int nexp);
        bad  = 0;
        nstr = 0;
        nexp = 0;
        pb   = mask;
        for (int i = 0; i < len + gap; i++) begin
            if (i == len) pb = '0;
            tick();
            if (strobe !== exp_str(i, len)) bad++;
            if (strobe === 1'b1) nstr++;
            if (exp_str(i, len)) nexp++;
        end
    endtask

    task automatic test_reset();
        int bad;
        pb    = 21'h1FFFFF;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (keycode !== 5'd0) begin failures++; $display("FAIL reset_keycode: got %0d expected 0", keycode); end
        checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %0b expected 0", strobe); end
        checks++; if (held !== 1'b0) begin failures++; $display("FAIL reset_held: got %0b expected 0", held); end
        checks++; if (keycnt !== 8'd0) begin failures++; $display("FAIL reset_keycnt: got %0d expected 0", keycnt); end
        reset = 1'b0;
        exp_keycnt = 8'd0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (strobe !== (i == D + 1)) bad++;
            if (i == D + 1) begin
                checks++; if (keycode !== 5'd20) begin failures++; $display("FAIL reset_first_code: got %0d expected 20", keycode); end
            end
        end
        exp_keycnt = 8'd1;
        last_code  = 5'd20;
        checks++; if (bad !== 0) begin failures++; $display("FAIL reset_strobe_timing: got %0d bad cycles expected 0", bad); end
        pb = '0;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (held !== 1'b0) begin failures++; $display("FAIL reset_release_held: got %0b expected 0", held); end
        checks++; if (keycnt !== exp_keycnt) begin failures++; $display("FAIL reset_keycnt_after: got %0d expected %0d", keycnt, exp_keycnt); end
        $display("test_reset done keycnt=%0d", keycnt);
    endtask

    task automatic test_clean_press();
        int bad_s, bad_h, nexp;
        bad_s = 0; bad_h = 0; nexp = 0;
        for (int i = 0; i < 20; i++) begin
            pb = (i < 12) ? 21'h000020 : 21'h0;
            tick();
            if (strobe !== exp_str(i, 12)) bad_s++;
            if (exp_str(i, 12)) nexp++;
            if (held !== (i >= D + 1 && i < 12 + D + 1)) bad_h++;
            if (i == D + 1) begin
                checks++; if (keycode !== 5'd5) begin failures++; $display("FAIL clean_keycode: got %0d expected 5", keycode); end
                checks++; if (keycnt !== exp_keycnt + 8'd1) begin failures++; $display("FAIL clean_keycnt_edge: got %0d expected %0d", keycnt, exp_keycnt + 8'd1); end
            end
        end
        exp_keycnt = exp_keycnt + 8'(nexp);
        last_code  = 5'd5;
        checks++; if (bad_s !== 0) begin failures++; $display("FAIL clean_strobe_timing: got %0d bad cycles expected 0", bad_s); end
        checks++; if (bad_h !== 0) begin failures++; $display("FAIL clean_held_timing: got %0d bad cycles expected 0", bad_h); end
        checks++; if (keycnt !== exp_keycnt) begin failures++; $display("FAIL clean_keycnt: got %0d expected %0d", keycnt, exp_keycnt); end
        $display("test_clean_press done keycode=%0d keycnt=%0d", keycode, keycnt);
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        int nstr, nheld;
        pat = 6'b011011;
        nstr = 0; nheld = 0;
        for (int i = 0; i < 14; i++) begin
            pb = (i < 6 && pat[5 - i]) ? 21'h000008 : 21'h0;
            tick();
            if (strobe === 1'b1) nstr++;
            if (held === 1'b1) nheld++;
        end
        checks++; if (nstr !== 0) begin failures++; $display("FAIL bounce_strobe: got %0d strobes expected 0", nstr); end
        checks++; if (nheld !== 0) begin failures++; $display("FAIL bounce_held: got %0d held cycles expected 0", nheld); end
        checks++; if (keycnt !== exp_keycnt) begin failures++; $display("FAIL bounce_keycnt: got %0d expected %0d", keycnt, exp_keycnt); end
        $display("test_bounce done keycnt=%0d", keycnt);
    endtask

    task automatic test_priority();
        int bad, nexp;
        bad = 0; nexp = 0;
        for (int i = 0; i < 30; i++) begin
            pb = (i < 8) ? 21'h020004 : ((i < 20) ? 21'h000004 : 21'h0);
            tick();
            if (strobe !== exp_str(i, 20)) bad++;
            if (exp_str(i, 20)) nexp++;
            if (i == D + 1) begin
                checks++; if (keycode !== 5'd17) begin failures++; $display("FAIL priority_keycode: got %0d expected 17", keycode); end
            end
        end
        exp_keycnt = exp_keycnt + 8'(nexp);
        last_code  = 5'd17;
        checks++; if (bad !== 0) begin failures++; $display("FAIL priority_strobe_timing: got %0d bad cycles expected 0", bad); end
        checks++; if (keycode !== 5'd17) begin failures++; $display("FAIL priority_hold_keycode: got %0d expected 17", keycode); end
        checks++; if (keycnt !== exp_keycnt) begin failures++; $display("FAIL priority_keycnt: got %0d expected %0d", keycnt, exp_keycnt); end
        $display("test_priority done keycode=%0d keycnt=%0d", keycode, keycnt);
    endtask

    task automatic test_release_glitch();
        int bad_s, bad_h;
        bad_s = 0; bad_h = 0;
        for (int i = 0; i < 20; i++) begin
            pb = (i < 6 || (i >= 7 && i < 10)) ? 21'h000020 : 21'h0;
            tick();
            if (strobe !== (i == D + 1)) bad_s++;
            if (held !== (i >= D + 1 && i < 10 + D + 1)) bad_h++;
        end
        exp_keycnt = exp_keycnt + 8'd1;
        last_code  = 5'd5;
        checks++; if (bad_s !== 0) begin failures++; $display("FAIL glitch_strobe: got %0d bad cycles expected 0", bad_s); end
        checks++; if (bad_h !== 0) begin failures++; $display("FAIL glitch_held: got %0d bad cycles expected 0", bad_h); end
        checks++; if (keycnt !== exp_keycnt) begin failures++; $display("FAIL glitch_keycnt: got %0d expected %0d", keycnt, exp_keycnt); end
        $display("test_release_glitch done keycnt=%0d", keycnt);
    endtask

    task automatic test_autorepeat();
        int bad, nstr, nexp, want;
`ifdef PB_AUTOREPEAT_EN
        want = 8;
`else
        want = 1;
`endif
        drive_press(21'h000200, 20, D + 6, bad, nstr, nexp);
        exp_keycnt = exp_keycnt + 8'(nexp);
        last_code  = 5'd9;
        checks++; if (bad !== 0) begin failures++; $display("FAIL autorepeat_timing: got %0d bad cycles expected 0", bad); end
        checks++; if (nstr !== want) begin failures++; $display("FAIL autorepeat_count: got %0d strobes expected %0d", nstr, want); end
        checks++; if (keycnt !== exp_keycnt) begin failures++; $display("FAIL autorepeat_keycnt: got %0d expected %0d", keycnt, exp_keycnt); end
        $display("test_autorepeat done strobes=%0d keycnt=%0d", nstr, keycnt);
    endtask

    task automatic test_random();
        logic [20:0] mask;
        int len, gap, bad, nstr, nexp;
        for (int n = 0; n < 24; n++) begin
            mask = 21'($urandom) & 21'h1FFFFF;
            if ($urandom_range(0, 2) == 0) mask = 21'h1 << $urandom_range(0, 20);
            if (mask == 21'h0) mask = 21'h000001;
            len = $urandom_range(1, 24);
            gap = $urandom_range(D + 3, D + 8);
            drive_press(mask, len, gap, bad, nstr, nexp);
            exp_keycnt = exp_keycnt + 8'(nexp);
            if (nexp > 0) last_code = top_index(mask);
            checks++;
            if (bad !== 0 || nstr !== nexp || keycode !== last_code || keycnt !== exp_keycnt || held !== 1'b0) begin
                failures++;
                $display("FAIL random_press%0d: mask=%h len=%0d got strobes=%0d code=%0d cnt=%0d held=%0b expected strobes=%0d code=%0d cnt=%0d held=0",
                         n, mask, len, nstr, keycode, keycnt, held, nexp, last_code, exp_keycnt);
            end
            $display("random press %0d mask=%h len=%0d strobes=%0d keycode=%0d keycnt=%0d", n, mask, len, nstr, keycode, keycnt);
        end
    endtask

    task automatic test_wrap();
        int bad, nstr, nexp, bad_total;
        bad_total = 0;
        for (int n = 0; n < 300 && exp_keycnt != 8'd255; n++) begin
            drive_press(21'h000002, D, D + 4, bad, nstr, nexp);
            exp_keycnt = exp_keycnt + 8'(nexp);
            bad_total += bad;
        end
        last_code = 5'd1;
        checks++; if (keycnt !== 8'd255) begin failures++; $display("FAIL wrap_preload: got %0d expected 255", keycnt); end
        drive_press(21'h000002, D, D + 4, bad, nstr, nexp);
        exp_keycnt = exp_keycnt + 8'(nexp);
        bad_total += bad;
        checks++; if (keycnt !== 8'd0) begin failures++; $display("FAIL wrap_keycnt: got %0d expected 0", keycnt); end
        checks++; if (bad_total !== 0) begin failures++; $display("FAIL wrap_strobe_timing: got %0d bad cycles expected 0", bad_total); end
        $display("test_wrap done keycnt=%0d", keycnt);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_priority();
        test_release_glitch();
        test_autorepeat();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
